// File: rtl/tm_frame_rx.sv
// tm_frame_rx: telemetry UART receiver, 0xEB 0x90 sync hunt, length/payload
// capture into a 64x8 RAM write port, additive checksum check.
// Ports: clk, rst (async, active-low), rxd (serial, idle high),
//   ram_addr/ram_din/ram_we (payload write port), frame_len (last good length),
//   frame_ok/frame_err (1-cycle result pulses), busy (frame in progress).
// Option: define TM_RX_PARITY_EN for 8E1 (even parity bit before stop).
module tm_frame_rx #(
    parameter int OVS_DIV = 26,
    parameter int MAX_LEN = 48,
    parameter int TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [5:0] ram_addr,
    output logic [7:0] ram_din,
    output logic       ram_we,
    output logic [5:0] frame_len,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_W    = $clog2(OVS_DIV);
    localparam int BIT_CLKS = 16 * OVS_DIV;
    localparam int BW       = $clog2(BIT_CLKS);
    localparam int GW       = $clog2(TIMEOUT + 1);

    // ---------------- input synchroniser ----------------
    logic [1:0] sync_q;
    logic       rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b11;
        else      sync_q <= {sync_q[0], rxd};
    end

    assign rxs = sync_q[1];

    // ---------------- byte FSM ----------------
    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
`ifdef TM_RX_PARITY_EN
        B_PAR,
`endif
        B_STOP
    } bstate_t;

    bstate_t          bs_q, bs_d;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       tcnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shf_q;
    logic             tick;
    logic             samp;
    logic             par_err;
    logic             byte_vld;
    logic             byte_ferr;

    // Divider is held in IDLE so every sample point is
    // a fixed distance from the detected start edge.
    assign tick = (div_q == DIV_W'(OVS_DIV - 1));
    // Tick count 7 hits mid start bit, then every 16 ticks.
    assign samp = tick && (tcnt_q == 4'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) bs_q <= B_IDLE;
        else      bs_q <= bs_d;
    end

    always_comb begin
        bs_d = bs_q;
        unique case (bs_q)
            B_IDLE:  if (!rxs) bs_d = B_START;
            B_START: if (samp) bs_d = rxs ? B_IDLE : B_DATA;
`ifdef TM_RX_PARITY_EN
            B_DATA:  if (samp && bit_q == 3'd7) bs_d = B_PAR;
            B_PAR:   if (samp) bs_d = B_STOP;
`else
            B_DATA:  if (samp && bit_q == 3'd7) bs_d = B_STOP;
`endif
            B_STOP:  if (samp) bs_d = B_IDLE;
            default: bs_d = B_IDLE;
        endcase
    end

    always_comb begin
        byte_vld  = 1'b0;
        byte_ferr = 1'b0;
        if (bs_q == B_STOP && samp) begin
            byte_vld  = rxs && !par_err;
            byte_ferr = !(rxs && !par_err);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tcnt_q <= '0;
            bit_q  <= '0;
            shf_q  <= '0;
        end else if (bs_q == B_IDLE) begin
            div_q  <= '0;
            tcnt_q <= '0;
            bit_q  <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + 1'b1;
            if (tick) tcnt_q <= tcnt_q + 4'd1;
            if (bs_q == B_DATA && samp) begin
                shf_q <= {rxs, shf_q[7:1]};
                bit_q <= bit_q + 3'd1;
            end
        end
    end

`ifdef TM_RX_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     par_err_q <= 1'b0;
        else if (bs_q == B_IDLE)      par_err_q <= 1'b0;
        else if (bs_q == B_PAR && samp)
            par_err_q <= (^shf_q) ^ rxs;
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    // ---------------- frame parser ----------------
    typedef enum logic [2:0] {
        P_HUNT1,
        P_HUNT2,
        P_LEN,
        P_PAY,
        P_CHK
    } pstate_t;

    pstate_t   ps_q, ps_d;
    logic [5:0] len_q;
    logic [5:0] idx_q;
    logic [7:0] sum_q;
    logic       len_ok;
    logic       tmo;
    logic       ok_d, err_d, we_d;
    logic [BW-1:0] gap_clk_q;
    logic [GW-1:0] gap_bits_q;

    assign len_ok = (shf_q != 8'd0) && (shf_q <= 8'(MAX_LEN));
    assign busy   = (ps_q == P_PAY) || (ps_q == P_CHK);
    assign tmo    = busy && (gap_bits_q == GW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ps_q <= P_HUNT1;
        else      ps_q <= ps_d;
    end

    always_comb begin
        ps_d = ps_q;
        if (byte_ferr || tmo) begin
            ps_d = P_HUNT1;
        end else if (byte_vld) begin
            unique case (ps_q)
                P_HUNT1: if (shf_q == 8'hEB) ps_d = P_HUNT2;
                P_HUNT2: begin
                    if (shf_q == 8'h90)      ps_d = P_LEN;
                    else if (shf_q != 8'hEB) ps_d = P_HUNT1;
                end
                P_LEN:   ps_d = len_ok ? P_PAY : P_HUNT1;
                P_PAY:   if (idx_q == len_q - 6'd1) ps_d = P_CHK;
                P_CHK:   ps_d = P_HUNT1;
                default: ps_d = P_HUNT1;
            endcase
        end
    end

    always_comb begin
        ok_d  = 1'b0;
        err_d = 1'b0;
        we_d  = 1'b0;
        if (byte_ferr) begin
            err_d = busy;
        end else if (tmo) begin
            err_d = 1'b1;
        end else if (byte_vld) begin
            unique case (1'b1)
                ps_q == P_LEN: err_d = !len_ok;
                ps_q == P_PAY: we_d  = 1'b1;
                ps_q == P_CHK: begin
                    ok_d  = (shf_q == sum_q);
                    err_d = (shf_q != sum_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_we    <= 1'b0;
            ram_din   <= '0;
            ram_addr  <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            frame_len <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
        end else begin
            ram_we    <= we_d;
            frame_ok  <= ok_d;
            frame_err <= err_d;
            if (byte_vld && ps_q == P_LEN && len_ok) begin
                len_q <= shf_q[5:0];
                sum_q <= shf_q;
                idx_q <= '0;
            end
            if (we_d) begin
                ram_din  <= shf_q;
                ram_addr <= idx_q;
                sum_q    <= sum_q + shf_q;
                idx_q    <= idx_q + 6'd1;
            end
            if (ok_d) frame_len <= len_q;
        end
    end

    // Inter-byte gap, measured in bit times since the last byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap_clk_q  <= '0;
            gap_bits_q <= '0;
        end else if (!busy || byte_vld) begin
            gap_clk_q  <= '0;
            gap_bits_q <= '0;
        end else if (gap_clk_q == BW'(BIT_CLKS - 1)) begin
            gap_clk_q  <= '0;
            gap_bits_q <= gap_bits_q + 1'b1;
        end else begin
            gap_clk_q <= gap_clk_q + 1'b1;
        end
    end

endmodule
